// File: rtl/layer_act_serializer_if.sv
// layer_act_serializer_if
// Valid/ready beat stream carrying one activation per beat.
//   m_valid : beat valid (master -> slave)
//   m_data  : activation value
//   m_index : element index of the beat
//   m_last  : final element of the layer
//   m_ready : downstream accept (slave -> master)
interface layer_act_serializer_if #(
    parameter int WIDTH = 8,
    parameter int IDX_W = 4
);
    logic             m_valid;
    logic [WIDTH-1:0] m_data;
    logic [IDX_W-1:0] m_index;
    logic             m_last;
    logic             m_ready;

    modport master (output m_valid, m_data, m_index, m_last, input m_ready);
    modport slave  (input m_valid, m_data, m_index, m_last, output m_ready);
endinterface

// File: rtl/layer_act_serializer.sv
// layer_act_serializer
// Captures NUM_ACT parallel post-ReLU activations LATENCY edges after start
// and streams them out one per beat, index 0 first.
// Optional argmax tracker built when LAYER_ACT_ARGMAX_EN is defined;
// otherwise max_idx/max_val/max_valid are tied to 0.
// Ports:
//   clk       : clock, rising edge
//   reset     : synchronous reset, active-low
//   start     : request one pass (sampled only in IDLE)
//   act_in    : flattened activations, element i at [i*WIDTH +: WIDTH]
//   busy      : high in WAIT and SEND
//   m         : output beat stream (master modport)
//   max_idx   : index of the largest streamed value
//   max_val   : largest streamed value
//   max_valid : one-cycle pulse after the final handshake
//
// state  | meaning
// S_IDLE | waiting for start
// S_WAIT | counting down pipeline latency before capture
// S_SEND | streaming captured buffer
module layer_act_serializer #(
    parameter int NUM_ACT = 15,
    parameter int WIDTH   = 8,
    parameter int LATENCY = 3,
    parameter int IDX_W   = $clog2(NUM_ACT)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [NUM_ACT*WIDTH-1:0]   act_in,
    output logic                       busy,
    layer_act_serializer_if.master     m,
    output logic [IDX_W-1:0]           max_idx,
    output logic [WIDTH-1:0]           max_val,
    output logic                       max_valid
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_SEND} state_t;

    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = (LATENCY > 0) ? CNT_W'(LATENCY - 1) : '0;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ACT - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d, idx_inc;
    logic [WIDTH-1:0] data_q, data_d;
    logic             last_q, last_d;
    logic             valid_q, busy_q;
    logic             capture, hs, hs_last;
    logic [WIDTH-1:0] act_buf_q [NUM_ACT];

    assign hs      = valid_q & m.m_ready;
    assign hs_last = hs & (idx_q == LAST_IDX);
    assign idx_inc = idx_q + 1'b1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        data_d  = data_q;
        last_d  = last_q;
        capture = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (LATENCY == 0) begin
                        capture = 1'b1;
                        state_d = S_SEND;
                    end else begin
                        cnt_d   = CNT_LOAD;
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    capture = 1'b1;
                    state_d = S_SEND;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_SEND: begin
                if (hs_last) begin
                    state_d = S_IDLE;
                    idx_d   = '0;
                    data_d  = '0;
                    last_d  = 1'b0;
                end else if (hs) begin
                    // Output registers are preloaded with the next element so
                    // nothing downstream sees a path from m_ready.
                    idx_d  = idx_inc;
                    data_d = act_buf_q[idx_inc];
                    last_d = (idx_inc == LAST_IDX);
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (capture) begin
            idx_d  = '0;
            data_d = act_in[0 +: WIDTH];
            last_d = (NUM_ACT == 1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            data_q  <= '0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            for (int i = 0; i < NUM_ACT; i++) act_buf_q[i] <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            last_q  <= last_d;
            valid_q <= (state_d == S_SEND);
            busy_q  <= (state_d != S_IDLE);
            if (capture) begin
                for (int i = 0; i < NUM_ACT; i++) act_buf_q[i] <= act_in[i*WIDTH +: WIDTH];
            end
        end
    end

    assign busy      = busy_q;
    assign m.m_valid = valid_q;
    assign m.m_data  = data_q;
    assign m.m_index = idx_q;
    assign m.m_last  = last_q;

`ifdef LAYER_ACT_ARGMAX_EN
    logic [IDX_W-1:0] max_idx_q;
    logic [WIDTH-1:0] max_val_q;
    logic             max_valid_q;

    // Strictly-greater update keeps the lower index on ties.
    always_ff @(posedge clk) begin
        if (!reset) begin
            max_idx_q   <= '0;
            max_val_q   <= '0;
            max_valid_q <= 1'b0;
        end else begin
            max_valid_q <= hs_last;
            if (capture) begin
                max_idx_q <= '0;
                max_val_q <= '0;
            end else if (hs && (data_q > max_val_q)) begin
                max_idx_q <= idx_q;
                max_val_q <= data_q;
            end
        end
    end

    assign max_idx   = max_idx_q;
    assign max_val   = max_val_q;
    assign max_valid = max_valid_q;
`else
    assign max_idx   = '0;
    assign max_val   = '0;
    assign max_valid = 1'b0;
`endif

endmodule

// File: tb/tb_layer_act_serializer.sv
module tb_layer_act_serializer;
    localparam int N  = 15;
    localparam int W  = 8;
    localparam int L  = 3;
    localparam int IW = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [N*W-1:0]   act_in;
    logic             busy;
    logic [IW-1:0]    max_idx;
    logic [W-1:0]     max_val;
    logic             max_valid;

    layer_act_serializer_if #(.WIDTH(W), .IDX_W(IW)) s_if ();

    layer_act_serializer #(.NUM_ACT(N), .WIDTH(W), .LATENCY(L), .IDX_W(IW)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .act_in    (act_in),
        .busy      (busy),
        .m         (s_if),
        .max_idx   (max_idx),
        .max_val   (max_val),
        .max_valid (max_valid)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [IW-1:0] idx;
        logic [W-1:0]  data;
        logic          last;
    } beat_t;

    beat_t         sb[$];
    int            total = 0;
    int            bad   = 0;
    logic          prev_hold = 1'b0;
    logic [W-1:0]  prev_data = '0;
    logic [IW-1:0] prev_idx  = '0;
    logic          prev_last = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock: check the beat about to be accepted, then advance past the edge.
    task automatic step();
        beat_t e;
        @(negedge clk);
        if (prev_hold) begin
            chk("hold_data", s_if.m_data, prev_data);
            chk("hold_index", s_if.m_index, prev_idx);
            chk("hold_last", s_if.m_last, prev_last);
        end
        if (s_if.m_valid && s_if.m_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_beat_sb_size", sb.size(), 1);
            end else begin
                e = sb.pop_front();
                chk("beat_index", s_if.m_index, e.idx);
                chk("beat_data", s_if.m_data, e.data);
                chk("beat_last", s_if.m_last, e.last);
            end
        end
        prev_hold = s_if.m_valid && !s_if.m_ready;
        prev_data = s_if.m_data;
        prev_idx  = s_if.m_index;
        prev_last = s_if.m_last;
        @(posedge clk);
        #1;
    endtask

    task automatic push_expect(input logic [N*W-1:0] vals);
        beat_t e;
        for (int i = 0; i < N; i++) begin
            e.idx  = IW'(i);
            e.data = vals[i*W +: W];
            e.last = (i == N - 1);
            sb.push_back(e);
        end
    endtask

    task automatic model_max(input logic [N*W-1:0] vals, output logic [IW-1:0] mi, output logic [W-1:0] mv);
`ifdef LAYER_ACT_ARGMAX_EN
        mi = '0;
        mv = vals[0 +: W];
        for (int i = 1; i < N; i++) begin
            if (vals[i*W +: W] > mv) begin
                mv = vals[i*W +: W];
                mi = IW'(i);
            end
        end
`else
        mi = '0;
        mv = '0;
`endif
    endtask

    task automatic run_pass(input logic [N*W-1:0] vals, input bit bp, output int pulses,
                            output logic [IW-1:0] mi, output logic [W-1:0] mv);
        int ph;
        int guard;
        ph = 0;
        guard = 0;
        pulses = 0;
        mi = '0;
        mv = '0;
        push_expect(vals);
        act_in = vals;
        start  = 1'b1;
        step();
        start  = 1'b0;
        while ((sb.size() != 0 || busy) && guard < 300) begin
            s_if.m_ready = bp ? ((ph % 4 == 0) || (ph % 4 == 3)) : 1'b1;
            ph++;
            step();
            guard++;
            if (max_valid) begin
                pulses++;
                mi = max_idx;
                mv = max_val;
            end
        end
        s_if.m_ready = 1'b1;
        chk("pass_within_budget", (guard < 300), 1);
        chk("pass_sb_empty", sb.size(), 0);
        step();
        if (max_valid) pulses++;
    endtask

    logic [N*W-1:0] vals;
    logic [IW-1:0]  emi, gmi;
    logic [W-1:0]   emv, gmv;
    int             pulses;
    int             exp_pulses;
    int             guard;

    initial begin
`ifdef LAYER_ACT_ARGMAX_EN
        exp_pulses = 1;
`else
        exp_pulses = 0;
`endif
        reset = 1'b0;
        start = 1'b1;
        act_in = '0;
        s_if.m_ready = 1'b1;

        // Reset held with start asserted
        step();
        step();
        chk("rst_busy", busy, 0);
        chk("rst_valid", s_if.m_valid, 0);
        chk("rst_data", s_if.m_data, 0);
        chk("rst_index", s_if.m_index, 0);
        chk("rst_last", s_if.m_last, 0);
        chk("rst_max_idx", max_idx, 0);
        chk("rst_max_val", max_val, 0);
        chk("rst_max_valid", max_valid, 0);
        reset = 1'b1;
        start = 1'b0;
        step();
        chk("idle_busy", busy, 0);

        // Basic pass with cycle-accurate timing, values i*10
        for (int i = 0; i < N; i++) vals[i*W +: W] = W'(i * 10);
        push_expect(vals);
        act_in = vals;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("basic_busy_after_start", busy, 1);
        for (int k = 1; k <= 20; k++) begin
            step();
            if (k < L) chk("basic_valid_before_capture", s_if.m_valid, 0);
            if (k == L) begin
                chk("basic_first_valid", s_if.m_valid, 1);
                chk("basic_first_index", s_if.m_index, 0);
            end
            if (k == L + N - 1) chk("basic_busy_before_last", busy, 1);
            if (k == L + N) begin
                chk("basic_busy_after_last", busy, 0);
                chk("basic_valid_after_last", s_if.m_valid, 0);
                chk("basic_sb_empty", sb.size(), 0);
                model_max(vals, emi, emv);
                chk("basic_max_valid", max_valid, exp_pulses);
                chk("basic_max_idx", max_idx, emi);
                chk("basic_max_val", max_val, emv);
            end
            if (k == L + N + 1) chk("basic_max_valid_drop", max_valid, 0);
        end

        // Backpressure pattern 1,0,0,1
        for (int i = 0; i < N; i++) vals[i*W +: W] = W'(i * 7 + 3);
        run_pass(vals, 1'b1, pulses, gmi, gmv);
        chk("bp_busy_end", busy, 0);
        chk("bp_max_pulses", pulses, exp_pulses);

        // Input change after capture plus start during SEND
        for (int i = 0; i < N; i++) vals[i*W +: W] = W'(200 - i * 5);
        push_expect(vals);
        act_in = vals;
        start = 1'b1;
        step();
        start = 1'b0;
        guard = 0;
        while (!s_if.m_valid && guard < 10) begin
            step();
            guard++;
        end
        chk("chg_valid_reached", s_if.m_valid, 1);
        act_in = '1;
        for (int j = 0; j < 4; j++) step();
        start = 1'b1;
        step();
        start = 1'b0;
        guard = 0;
        while (busy && guard < 50) begin
            step();
            guard++;
        end
        for (int j = 0; j < 10; j++) step();
        chk("chg_no_second_pass_busy", busy, 0);
        chk("chg_no_second_pass_valid", s_if.m_valid, 0);
        chk("chg_sb_empty", sb.size(), 0);

        // Reset at beat 5
        for (int i = 0; i < N; i++) vals[i*W +: W] = W'(i + 1);
        push_expect(vals);
        act_in = vals;
        start = 1'b1;
        step();
        start = 1'b0;
        guard = 0;
        while (!(s_if.m_valid && s_if.m_index == 4'd5) && guard < 20) begin
            step();
            guard++;
        end
        chk("mid_reached_beat5", s_if.m_index, 5);
        reset = 1'b0;
        step();
        chk("mid_valid", s_if.m_valid, 0);
        chk("mid_last", s_if.m_last, 0);
        chk("mid_busy", busy, 0);
        chk("mid_index", s_if.m_index, 0);
        chk("mid_data", s_if.m_data, 0);
        reset = 1'b1;
        sb.delete();
        for (int i = 0; i < N; i++) vals[i*W +: W] = W'(i * 3);
        run_pass(vals, 1'b0, pulses, gmi, gmv);
        chk("post_rst_busy", busy, 0);

        // Argmax with a tie at 90
        vals[0*W +: W] = 8'd3;
        vals[1*W +: W] = 8'd90;
        vals[2*W +: W] = 8'd7;
        vals[3*W +: W] = 8'd90;
        for (int i = 4; i < N - 1; i++) vals[i*W +: W] = W'(i);
        vals[(N-1)*W +: W] = 8'd0;
        model_max(vals, emi, emv);
        run_pass(vals, 1'b0, pulses, gmi, gmv);
        chk("argmax_pulses", pulses, exp_pulses);
        chk("argmax_idx_at_pulse", gmi, emi);
        chk("argmax_val_at_pulse", gmv, emv);
        for (int j = 0; j < 5; j++) step();
        chk("argmax_idx_hold", max_idx, emi);
        chk("argmax_val_hold", max_val, emv);
        chk("argmax_valid_low", max_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
